// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: applies the single-step 16-bit shifter once
// per clock until the captured amount is used up, then pulses done for one
// cycle. One request is handled at a time; start is ignored while busy.
module shift_sequencer #(
    parameter int unsigned AMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      in,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [15:0]      out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      acc;
    logic [1:0]       op_q;
    logic [AMT_W-1:0] cnt;
    logic [15:0]      step;
    logic             no_shift;
    logic             last_step;

    // Single-step shifter applied to the accumulator with the captured code
    always_comb begin
        step = acc;
        case (op_q)
            2'b00:   step = acc;
            2'b01:   step = {acc[14:0], 1'b0};
            2'b10:   step = {1'b0, acc[15:1]};
            default: step = {acc[15], acc[15:1]};
        endcase
    end

    // A pass code or zero amount means the request completes without shifting
    always_comb begin
        no_shift  = (op == 2'b00) || (amount == '0);
        last_step = (cnt == AMT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = no_shift ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture on accepted start, shift each SHIFT cycle, and load
    // the result register on the edge that enters DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            acc  <= '0;
            op_q <= '0;
            cnt  <= '0;
            out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= in;
                        op_q <= op;
                        cnt  <= amount;
                        if (no_shift) begin
                            out <= in;
                        end
                    end
                end
                SHIFT: begin
                    acc <= step;
                    cnt <= cnt - AMT_W'(1);
                    if (last_step) begin
                        out <= step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases followed by random
// requests compared against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in;
    logic [1:0]  op;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    shift_sequencer #(.AMT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in),
        .op     (op),
        .amount (amount),
        .busy   (busy),
        .done   (done),
        .out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int model_n(input logic [1:0] o, input logic [3:0] a);
        return (o == 2'b00) ? 0 : int'(a);
    endfunction

    function automatic logic [15:0] model_out(input logic [15:0] x, input logic [1:0] o, input int n);
        logic signed [15:0] sx;
        sx = x;
        case (o)
            2'b01:   return x << n;
            2'b10:   return x >> n;
            2'b11:   return sx >>> n;
            default: return x;
        endcase
    endfunction

    // Issue one request and follow it cycle by cycle. When inject is set,
    // start is pulsed with junk operands during every busy/done cycle.
    task automatic run_req(input string tag, input logic [15:0] d, input logic [1:0] o,
                           input logic [3:0] a, input logic [15:0] exp_out, input bit inject);
        int n;
        n = model_n(o, a);
        @(negedge clk);
        start = 1'b1; in = d; op = o; amount = a;
        @(posedge clk);
        for (int j = 0; j <= n + 2; j++) begin
            @(negedge clk);
            start = 1'b0; in = $urandom; op = 2'($urandom); amount = 4'($urandom);
            chk({tag, " busy"}, 16'(busy), 16'(j < n));
            chk({tag, " done"}, 16'(done), 16'(j == n));
            if (j == n || j == n + 2) chk({tag, " out"}, out, exp_out);
            if (inject && j <= n) begin
                start = 1'b1; in = 16'h1234; op = 2'b01; amount = 4'd2;
            end
        end
    endtask

    initial begin
        logic [15:0] d;
        logic [1:0]  o;
        logic [3:0]  a;
        bit          seen_done;

        reset = 1'b1; start = 1'b0; in = '0; op = '0; amount = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 16'(busy), 16'd0);
        chk("reset done", 16'(done), 16'd0);
        chk("reset out",  out, 16'h0000);
        reset = 1'b0;

        run_req("t1 left4",  16'b1011101010110111, 2'b01, 4'd4, 16'b1010101101110000, 1'b0);
        run_req("t2 asr4",   16'b1111000011001111, 2'b11, 4'd4, 16'b1111111100001100, 1'b0);
        run_req("t2 lsr4",   16'b1111000011001111, 2'b10, 4'd4, 16'b0000111100001100, 1'b0);
        run_req("t3 amt0",   16'hFFFF, 2'b01, 4'd0, 16'hFFFF, 1'b0);
        run_req("t3 pass",   16'hFFFF, 2'b00, 4'd9, 16'hFFFF, 1'b0);
        run_req("t4 lsr15",  16'h8000, 2'b10, 4'd15, 16'h0001, 1'b0);
        run_req("t4 asr15",  16'h8000, 2'b11, 4'd15, 16'hFFFF, 1'b0);
        run_req("t5 ignore", 16'h0001, 2'b01, 4'd3, 16'h0008, 1'b1);

        // Reset in the middle of a long request
        @(negedge clk);
        start = 1'b1; in = 16'h8000; op = 2'b11; amount = 4'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6 busy before reset", 16'(busy), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t6 busy after reset", 16'(busy), 16'd0);
        chk("t6 done after reset", 16'(done), 16'd0);
        chk("t6 out after reset",  out, 16'h0000);
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        chk("t6 no activity", 16'(seen_done), 16'd0);
        run_req("t6 fresh", 16'h0003, 2'b01, 4'd1, 16'h0006, 1'b0);

        // Random requests against the arithmetic model
        for (int r = 0; r < 24; r++) begin
            d = 16'($urandom);
            o = 2'($urandom_range(0, 3));
            a = 4'($urandom_range(0, 15));
            run_req("rand", d, o, a, model_out(d, o, model_n(o, a)), r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
